// File: rtl/dmem_master.sv
// Data-memory load/store initiator: drives the D_MEM VALID/READY port for one core request at a time.
// Builds strobes and replicated store data, waits for READY under a watchdog, and extends load data.
module dmem_master #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [1:0]  RSP_ERR,
  output logic [31:0] RSP_RDATA,
  output logic        D_MEM_VALID,
  input  logic        D_MEM_READY,
  output logic [3:0]  D_MEM_WSTB,
  output logic [31:0] D_MEM_ADDR,
  output logic [31:0] D_MEM_WDATA,
  input  logic [31:0] D_MEM_RDATA
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Abort fires on the edge that ends the TIMEOUT-th REQ cycle.
  localparam int              TO_LIM  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LIM);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [1:0]       size_q;
  logic [1:0]       off_q;
  logic             uns_q;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = (off != 2'd0);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    strobe = 4'b0001 << off;
      2'd1:    strobe = 4'b0011 << off;
      default: strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    replicate = {4{wdata[7:0]}};
      2'd1:    replicate = {2{wdata[15:0]}};
      default: replicate = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (size)
      2'd0:    load_ext = {{24{~uns & lane[7]}}, lane[7:0]};
      2'd1:    load_ext = {{16{~uns & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  endfunction

  assign REQ_READY = (state == S_IDLE);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      cnt         <= '0;
      D_MEM_VALID <= 1'b0;
      D_MEM_WSTB  <= 4'd0;
      D_MEM_ADDR  <= 32'd0;
      D_MEM_WDATA <= 32'd0;
      RSP_VALID   <= 1'b0;
      RSP_ERR     <= ERR_OK;
      RSP_RDATA   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ_VALID) begin
            we_q   <= REQ_WE;
            size_q <= REQ_SIZE;
            off_q  <= REQ_ADDR[1:0];
            uns_q  <= REQ_UNSIGNED;
            if (misaligned(REQ_SIZE, REQ_ADDR[1:0])) begin
              state     <= S_RESP;
              RSP_VALID <= 1'b1;
              RSP_ERR   <= ERR_ALIGN;
              RSP_RDATA <= 32'd0;
            end else begin
              state       <= S_REQ;
              cnt         <= '0;
              D_MEM_VALID <= 1'b1;
              D_MEM_WSTB  <= REQ_WE ? strobe(REQ_SIZE, REQ_ADDR[1:0]) : 4'd0;
              D_MEM_ADDR  <= {REQ_ADDR[31:2], 2'b00};
              D_MEM_WDATA <= replicate(REQ_SIZE, REQ_WDATA);
            end
          end
        end
        S_REQ: begin
          // READY is checked first so a completion in the last allowed cycle beats the watchdog.
          if (D_MEM_READY) begin
            state       <= S_RESP;
            D_MEM_VALID <= 1'b0;
            D_MEM_WSTB  <= 4'd0;
            RSP_VALID   <= 1'b1;
            RSP_ERR     <= ERR_OK;
            RSP_RDATA   <= we_q ? 32'd0 : load_ext(D_MEM_RDATA, size_q, off_q, uns_q);
          end else if ((TIMEOUT > 0) && (cnt == TO_LAST)) begin
            state       <= S_RESP;
            D_MEM_VALID <= 1'b0;
            D_MEM_WSTB  <= 4'd0;
            RSP_VALID   <= 1'b1;
            RSP_ERR     <= ERR_TIMEOUT;
            RSP_RDATA   <= 32'd0;
          end else if (TIMEOUT > 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          RSP_VALID <= 1'b0;
          RSP_ERR   <= ERR_OK;
          RSP_RDATA <= 32'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: scripted and randomized loads/stores against a byte-level memory model,
// with a programmable responder (registered-VALID, never-ready, ready-on-Nth-cycle, always-high).
module tb_dmem_master;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WE = 1'b0;
  logic [1:0]  REQ_SIZE = 2'd0;
  logic        REQ_UNSIGNED = 1'b0;
  logic [31:0] REQ_ADDR = 32'd0;
  logic [31:0] REQ_WDATA = 32'd0;
  logic        RSP_VALID;
  logic [1:0]  RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic        D_MEM_VALID;
  logic        D_MEM_READY = 1'b0;
  logic [3:0]  D_MEM_WSTB;
  logic [31:0] D_MEM_ADDR;
  logic [31:0] D_MEM_WDATA;
  logic [31:0] D_MEM_RDATA = 32'd0;

  dmem_master #(.TIMEOUT(4), .CNT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE),
    .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .RSP_RDATA(RSP_RDATA),
    .D_MEM_VALID(D_MEM_VALID), .D_MEM_READY(D_MEM_READY), .D_MEM_WSTB(D_MEM_WSTB),
    .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_WDATA(D_MEM_WDATA), .D_MEM_RDATA(D_MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Responder memory (changed only by bus writes) and independent byte-level reference.
  logic [31:0] mem [0:1023];
  logic [7:0]  ref_bytes [0:4095];
  bit          mem_loaded = 1'b0;

  // 0: READY = registered VALID, 1: never, 2: READY on VALID cycle rdy_at, 3: always high
  int resp_mode = 0;
  int rdy_at = 1;
  logic prev_valid = 1'b0;
  int vcnt = 0;

  int vhigh_cnt = 0;
  int rise_cnt = 0;
  int rsp_cnt = 0;
  logic mon_prev = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (RST_N && D_MEM_VALID && D_MEM_READY) begin
      for (int b = 0; b < 4; b++)
        if (D_MEM_WSTB[b]) mem[D_MEM_ADDR[11:2]][8*b +: 8] <= D_MEM_WDATA[8*b +: 8];
    end
  end

  always @(negedge CLK) begin
    case (resp_mode)
      0:       D_MEM_READY <= prev_valid;
      1:       D_MEM_READY <= 1'b0;
      2:       D_MEM_READY <= D_MEM_VALID && (vcnt + 1 == rdy_at);
      default: D_MEM_READY <= 1'b1;
    endcase
    prev_valid  <= D_MEM_VALID;
    vcnt        <= D_MEM_VALID ? vcnt + 1 : 0;
    D_MEM_RDATA <= D_MEM_VALID ? mem[D_MEM_ADDR[11:2]] : $urandom();
  end

  always @(posedge CLK) begin
    if (D_MEM_VALID) vhigh_cnt <= vhigh_cnt + 1;
    if (D_MEM_VALID && !mon_prev) rise_cnt <= rise_cnt + 1;
    if (RSP_VALID) rsp_cnt <= rsp_cnt + 1;
    mon_prev <= D_MEM_VALID;
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_misaligned(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || ((a % nbytes(s)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input bit uns, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = nbytes(s);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_bytes[(a + k) & 4095]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
    return v;
  endfunction

  function automatic void model_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < nbytes(s); k++) ref_bytes[(a + k) & 4095] = w[8*k +: 8];
  endfunction

  function automatic logic [3:0] model_wstb(input logic [1:0] s, input logic [31:0] a);
    logic [3:0] m;
    m = 4'd0;
    for (int k = 0; k < nbytes(s); k++) m[(a % 4) + k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] s, input logic [31:0] w);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) v[8*b +: 8] = w[8*(b % nbytes(s)) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  // ---------------- driver ----------------
  logic [1:0]  r_err;
  logic [31:0] r_rdata;
  int          r_lat;
  logic        r_dv;
  logic [3:0]  r_dw;
  logic [31:0] r_da, r_dd;
  logic        r_pv;
  logic [1:0]  r_pe;
  logic [31:0] r_pr;

  task automatic do_txn(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    guard = 0;
    while (!REQ_READY && guard < 50) begin @(negedge CLK); guard++; end
    REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = size; REQ_UNSIGNED = uns;
    REQ_ADDR = addr; REQ_WDATA = wdata;
    @(negedge CLK);
    REQ_VALID = 1'b0; REQ_ADDR = $urandom(); REQ_WDATA = $urandom();
    REQ_SIZE = 2'($urandom_range(0, 3)); REQ_WE = 1'($urandom_range(0, 1));
    r_dv = D_MEM_VALID; r_dw = D_MEM_WSTB; r_da = D_MEM_ADDR; r_dd = D_MEM_WDATA;
    r_lat = 1;
    while (!RSP_VALID && r_lat < 20) begin @(negedge CLK); r_lat++; end
    if (!RSP_VALID) begin
      checks++; failures++;
      $display("FAIL rsp_wait no RSP_VALID within %0d cycles of accept (addr=%h)", r_lat, addr);
      r_lat = -1;
    end
    r_err = RSP_ERR; r_rdata = RSP_RDATA;
    @(negedge CLK);
    r_pv = RSP_VALID; r_pe = RSP_ERR; r_pr = RSP_RDATA;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", REQ_READY); end
    checks++; if ({D_MEM_VALID, D_MEM_WSTB, D_MEM_ADDR, D_MEM_WDATA} !== 69'd0) begin failures++;
      $display("FAIL reset_bus got v=%b s=%h a=%h d=%h exp all 0", D_MEM_VALID, D_MEM_WSTB, D_MEM_ADDR, D_MEM_WDATA); end
    checks++; if ({RSP_VALID, RSP_ERR, RSP_RDATA} !== 35'd0) begin failures++;
      $display("FAIL reset_rsp got v=%b e=%0d d=%h exp all 0", RSP_VALID, RSP_ERR, RSP_RDATA); end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_store_word();
    do_txn(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    model_store(2'd2, 32'h100, 32'hDEADBEEF);
    checks++; if ({r_dv, r_dw} !== {1'b1, 4'hF}) begin failures++; $display("FAIL sw_valid_wstb got v=%b s=%h exp v=1 s=f", r_dv, r_dw); end
    checks++; if (r_da !== 32'h100) begin failures++; $display("FAIL sw_addr got=%h exp=00000100", r_da); end
    checks++; if (r_dd !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", r_dd); end
    checks++; if (r_lat != 3) begin failures++; $display("FAIL sw_latency got=%0d exp=3", r_lat); end
    checks++; if ({r_err, r_rdata} !== 34'd0) begin failures++; $display("FAIL sw_rsp got err=%0d rdata=%h exp 0/0", r_err, r_rdata); end
    checks++; if ({r_pv, r_pe, r_pr} !== 35'd0) begin failures++; $display("FAIL sw_rsp_clear got v=%b e=%0d d=%h exp 0", r_pv, r_pe, r_pr); end
    checks++; if (mem[64] !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[64]); end
  endtask

  task automatic test_back_to_back();
    int v0, r0, p0;
    do_txn(1'b1, 2'd0, 1'b0, 32'h101, 32'h000000A5);
    model_store(2'd0, 32'h101, 32'h000000A5);
    checks++; if (r_dw !== 4'b0010) begin failures++; $display("FAIL sb_wstb got=%b exp=0010", r_dw); end
    checks++; if (r_dd !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", r_dd); end
    checks++; if (mem[64] !== ref_word(64)) begin failures++; $display("FAIL sb_mem got=%h exp=%h", mem[64], ref_word(64)); end
    v0 = vhigh_cnt; r0 = rise_cnt; p0 = rsp_cnt;
    do_txn(1'b0, 2'd0, 1'b0, 32'h101, 32'd0);
    checks++; if (r_rdata !== 32'hFFFFFFA5) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffffa5", r_rdata); end
    do_txn(1'b0, 2'd0, 1'b1, 32'h101, 32'd0);
    checks++; if (r_rdata !== 32'h000000A5) begin failures++; $display("FAIL lbu_rdata got=%h exp=000000a5", r_rdata); end
    checks++; if (vhigh_cnt - v0 != 4) begin failures++; $display("FAIL b2b_valid_cycles got=%0d exp=4", vhigh_cnt - v0); end
    checks++; if (rise_cnt - r0 != 2) begin failures++; $display("FAIL b2b_valid_rises got=%0d exp=2", rise_cnt - r0); end
    checks++; if (rsp_cnt - p0 != 2) begin failures++; $display("FAIL b2b_rsp_count got=%0d exp=2", rsp_cnt - p0); end
  endtask

  task automatic test_halfword();
    logic [31:0] exp_tab [3];
    logic [31:0] addr_tab [3];
    bit          uns_tab [3];
    exp_tab  = '{32'hFFFF8001, 32'h00008001, 32'h00001234};
    addr_tab = '{32'h102, 32'h102, 32'h100};
    uns_tab  = '{1'b0, 1'b1, 1'b0};
    do_txn(1'b1, 2'd2, 1'b0, 32'h100, 32'h80011234);
    model_store(2'd2, 32'h100, 32'h80011234);
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b0, 2'd1, uns_tab[i], addr_tab[i], 32'd0);
      checks++; if ({r_err, r_rdata} !== {2'd0, exp_tab[i]}) begin failures++;
        $display("FAIL half_load%0d got err=%0d rdata=%h exp err=0 rdata=%h", i, r_err, r_rdata, exp_tab[i]); end
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  size_tab [3];
    logic [31:0] addr_tab [3];
    bit          we_tab [3];
    int v0;
    size_tab = '{2'd2, 2'd1, 2'd3};
    addr_tab = '{32'h102, 32'h101, 32'h100};
    we_tab   = '{1'b0, 1'b1, 1'b1};
    resp_mode = 3;
    v0 = vhigh_cnt;
    for (int i = 0; i < 3; i++) begin
      do_txn(we_tab[i], size_tab[i], 1'b0, addr_tab[i], $urandom());
      checks++; if ({r_err, r_rdata} !== {2'd1, 32'd0}) begin failures++;
        $display("FAIL misalign%0d_rsp got err=%0d rdata=%h exp err=1 rdata=0", i, r_err, r_rdata); end
      checks++; if (r_lat != 1) begin failures++; $display("FAIL misalign%0d_latency got=%0d exp=1", i, r_lat); end
    end
    checks++; if (vhigh_cnt != v0) begin failures++; $display("FAIL misalign_bus got %0d VALID cycles exp=0", vhigh_cnt - v0); end
    checks++; if (mem[64] !== ref_word(64)) begin failures++; $display("FAIL misalign_mem got=%h exp=%h", mem[64], ref_word(64)); end
    resp_mode = 0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_timeout();
    int v0, p0;
    resp_mode = 1;
    @(negedge CLK);
    v0 = vhigh_cnt;
    do_txn(1'b1, 2'd2, 1'b0, 32'h180, 32'hCAFEF00D);
    checks++; if ({r_err, r_rdata} !== {2'd2, 32'd0}) begin failures++;
      $display("FAIL timeout_rsp got err=%0d rdata=%h exp err=2 rdata=0", r_err, r_rdata); end
    checks++; if (vhigh_cnt - v0 != 4) begin failures++; $display("FAIL timeout_valid_cycles got=%0d exp=4", vhigh_cnt - v0); end
    checks++; if (r_lat != 5) begin failures++; $display("FAIL timeout_latency got=%0d exp=5", r_lat); end
    p0 = rsp_cnt;
    resp_mode = 3;
    repeat (4) @(negedge CLK);
    checks++; if (rsp_cnt != p0) begin failures++; $display("FAIL late_ready_rsp got %0d responses exp=0", rsp_cnt - p0); end
    checks++; if (mem[96] !== ref_word(96)) begin failures++; $display("FAIL late_ready_mem got=%h exp=%h", mem[96], ref_word(96)); end
    resp_mode = 2; rdy_at = 4;
    repeat (2) @(negedge CLK);
    v0 = vhigh_cnt;
    do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    checks++; if ({r_err, r_rdata} !== {2'd0, model_load(2'd2, 1'b0, 32'h100)}) begin failures++;
      $display("FAIL ready_last_cycle got err=%0d rdata=%h exp err=0 rdata=%h", r_err, r_rdata, model_load(2'd2, 1'b0, 32'h100)); end
    checks++; if (vhigh_cnt - v0 != 4) begin failures++; $display("FAIL ready_last_valid_cycles got=%0d exp=4", vhigh_cnt - v0); end
    resp_mode = 0;
  endtask

  task automatic test_reset_mid();
    logic v1, v2;
    int p0;
    resp_mode = 1;
    @(negedge CLK);
    p0 = rsp_cnt;
    while (!REQ_READY) @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'd2; REQ_ADDR = 32'h200; REQ_WDATA = 32'h12345678;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    v1 = D_MEM_VALID;
    @(negedge CLK);
    v2 = D_MEM_VALID;
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    checks++; if ({v1, v2} !== 2'b11) begin failures++; $display("FAIL rstmid_in_req got valid=%b%b exp=11", v1, v2); end
    checks++; if ({D_MEM_VALID, D_MEM_WSTB, REQ_READY, RSP_VALID} !== 7'b0000010) begin failures++;
      $display("FAIL rstmid_state got v=%b s=%b rdy=%b rsp=%b exp v=0 s=0000 rdy=1 rsp=0", D_MEM_VALID, D_MEM_WSTB, REQ_READY, RSP_VALID); end
    checks++; if ({D_MEM_ADDR, D_MEM_WDATA} !== 64'd0) begin failures++;
      $display("FAIL rstmid_bus got a=%h d=%h exp 0", D_MEM_ADDR, D_MEM_WDATA); end
    repeat (4) @(negedge CLK);
    checks++; if (rsp_cnt != p0) begin failures++; $display("FAIL rstmid_no_rsp got %0d responses exp=0", rsp_cnt - p0); end
    checks++; if (mem[128] !== ref_word(128)) begin failures++; $display("FAIL rstmid_mem got=%h exp=%h", mem[128], ref_word(128)); end
    resp_mode = 0;
    @(negedge CLK);
  endtask

  task automatic test_random();
    bit          we, uns, mis;
    logic [1:0]  size, exp_err;
    logic [31:0] addr, wdata, exp_rd;
    int          exp_lat, bad;
    resp_mode = 2;
    for (int it = 0; it < 40; it++) begin
      we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); addr = $urandom(); wdata = $urandom();
      rdy_at = $urandom_range(0, 4);
      @(negedge CLK);
      mis = model_misaligned(size, addr);
      if (mis) begin exp_err = 2'd1; exp_lat = 1; end
      else if (rdy_at == 0) begin exp_err = 2'd2; exp_lat = 5; end
      else begin exp_err = 2'd0; exp_lat = rdy_at + 1; end
      exp_rd = (exp_err == 2'd0 && !we) ? model_load(size, uns, addr) : 32'd0;
      do_txn(we, size, uns, addr, wdata);
      if (exp_err == 2'd0 && we) model_store(size, addr, wdata);
      checks++; if ({r_err, r_rdata} !== {exp_err, exp_rd}) begin failures++;
        $display("FAIL rand%0d_rsp we=%b sz=%0d a=%h got err=%0d rd=%h exp err=%0d rd=%h", it, we, size, addr, r_err, r_rdata, exp_err, exp_rd); end
      checks++; if (r_lat != exp_lat) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, r_lat, exp_lat); end
      checks++; if (r_dv !== !mis) begin failures++; $display("FAIL rand%0d_valid got=%b exp=%b", it, r_dv, !mis); end
      if (!mis) begin
        checks++; if ({r_da, r_dw} !== {addr[31:2], 2'b00, (we ? model_wstb(size, addr) : 4'd0)}) begin failures++;
          $display("FAIL rand%0d_addr_wstb got a=%h s=%b exp a=%h s=%b", it, r_da, r_dw, {addr[31:2], 2'b00}, we ? model_wstb(size, addr) : 4'd0); end
        if (we) begin
          checks++; if (r_dd !== model_wdata(size, wdata)) begin failures++;
            $display("FAIL rand%0d_wdata got=%h exp=%h", it, r_dd, model_wdata(size, wdata)); end
        end
      end
      checks++; if ({r_pv, r_pe, r_pr} !== 35'd0) begin failures++; $display("FAIL rand%0d_rsp_clear got v=%b e=%0d d=%h exp 0", it, r_pv, r_pe, r_pr); end
    end
    resp_mode = 0;
    repeat (2) @(negedge CLK);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_word(i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL rand_memory got %0d differing words exp=0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = init_word(i) >> (8 * b);
    test_reset();
    test_store_word();
    test_back_to_back();
    test_halfword();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit run did not complete within 200000 time units");
    $fatal(1, "time limit");
  end

endmodule
